cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Run controller sequencing one program execution on the pipelined RISC-V core. It streams a program into instruction memory through the core's external instruction port and holds core `enable` high for a programmed number of cycles. It then reads all of data memory back out through the external data port as a valid/ready stream. It sits between the test host or loader and the `cpu` top-level external ports; it owns `enable`, `addr_ext*`, `wen_ext*`, `ren_ext*` and `wdata_ext*`.

## Interface
- IMEM_DEPTH, 128: instruction memory size in 32-bit words (power of 2, ≥2)
- DMEM_DEPTH, 128: data memory size in 64-bit doublewords (power of 2, ≥2)
- CNT_W, 32: width of the run-cycle counter

Ports:
- clk  in  1  clock; one clock for the block; all state on rising edge
- arst_n  in  1  asynchronous reset, active low
- start  in  1  1-cycle pulse; accepted only in IDLE; latches `run_cycles`
- abort  in  1  returns to IDLE from any state next cycle
- run_cycles  in  CNT_W  number of cycles `enable` is held high
- ld_valid / ld_ready  in/out  1  program word handshake
- ld_data  in  32  instruction word
- ld_last  in  1  marks final program word
- enable  out  1  core enable
- addr_ext  out  64  instruction memory byte address
- wen_ext  out  1  instruction memory write enable
- ren_ext  out  1  instruction memory read enable; always 0
- wdata_ext  out  32  instruction memory write data
- addr_ext_2  out  64  data memory byte address
- wen_ext_2  out  1  data memory write enable; always 0
- ren_ext_2  out  1  data memory read enable
- rdata_ext_2  in  64  data memory read data, valid 1 cycle after `ren_ext_2`
- dump_valid / dump_ready  out/in  1  dump stream handshake
- dump_data  out  64  doubleword read back
- dump_idx  out  log2(DMEM_DEPTH)  doubleword index of `dump_data`
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE

## Operation
- All outputs are registered. Reset value of every output is 0, and the state is IDLE.
- States:
  - IDLE → LOAD on `start`.
  - LOAD → RUN when a program write completes with `ld_last` or with index IMEM_DEPTH-1.
  - RUN → DUMP_RD when the cycle counter equals the latched `run_cycles`. If `run_cycles`=0, RUN lasts 0 cycles and the block enters DUMP_RD directly after LOAD.
  - DUMP_RD → DUMP_WAIT → DUMP_OUT → DUMP_RD (next index) or → DONE after index DMEM_DEPTH-1.
  - DONE → LOAD on `start`.
- LOAD:
  - `ld_ready`=1 except in the cycle a write is being issued.
  - Handshake k (0-based): next cycle `wen_ext`=1, `addr_ext`=4·k, `wdata_ext`=`ld_data` for exactly one cycle.
  - The word index wraps nowhere: the transfer ends at IMEM_DEPTH words even without `ld_last`.
- RUN: `enable`=1 for exactly `run_cycles` consecutive cycles. The counter is CNT_W bits, saturating, and restarts at 0 on each `start`.
- Dump read of index j:
  - DUMP_RD drives `ren_ext_2`=1 and `addr_ext_2`=8·j for one cycle.
  - In DUMP_WAIT, `rdata_ext_2` is captured.
  - DUMP_OUT holds `dump_valid`=1 with `dump_data` and `dump_idx`=j stable until `dump_ready`.
- `abort`: next cycle state=IDLE; `enable`, `wen_ext`, `ren_ext_2`, `ld_ready`, `dump_valid` = 0. An `abort` coincident with `start` wins.
- `start` is ignored outside IDLE and DONE.
- `ld_valid` is ignored outside LOAD.

## Timing
- `start` in cycle t → `ld_ready`=1 at t+1.
- Handshake at t → write visible at t+1.
- Final write at t → `enable`=1 at t+1 through t+`run_cycles`.
- First `ren_ext_2` at t+`run_cycles`+1.
- Dump throughput is one doubleword per 3 cycles with `dump_ready` tied high. `dump_valid` is asserted 2 cycles after `ren_ext_2`.
- `done` rises the cycle after the last dump handshake and stays high until `start`.
- Reset mid-run forces all outputs to 0 asynchronously.

## Test plan
- Reset in DUMP_OUT with `dump_valid`=1 → all outputs 0 immediately; state IDLE after release.
- Load 4 words 0x00000013.. with `ld_last` on word 3, `run_cycles`=10 → writes at addresses 0, 4, 8, 12 on consecutive handshakes; `enable` high exactly 10 cycles; then 128 dumps with `addr_ext_2` 0..1016 step 8.
- `ld_valid` held high, no `ld_last`, IMEM_DEPTH=128 → exactly 128 writes, last `addr_ext`=508; RUN entered.
- `run_cycles`=0 → `enable` never asserted; `ren_ext_2` the cycle after the final write.
- `dump_ready` low 5 cycles on index 3 → `dump_data` and `dump_idx`=3 stable; no further `ren_ext_2` until the handshake.
- `abort` on RUN cycle 4 of 10 → `enable`=0 the next cycle, state IDLE; a new `start` performs a full load again.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run controller for the pipelined core: streams a program into instruction
// memory, holds enable for a latched cycle count, then dumps all of data memory.
module cpu_run_ctrl #(
  parameter int IMEM_DEPTH = 128,
  parameter int DMEM_DEPTH = 128,
  parameter int CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [CNT_W-1:0]              run_cycles,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [31:0]                   ld_data,
  input  logic                          ld_last,
  output logic                          enable,
  output logic [63:0]                   addr_ext,
  output logic                          wen_ext,
  output logic                          ren_ext,
  output logic [31:0]                   wdata_ext,
  output logic [63:0]                   addr_ext_2,
  output logic                          wen_ext_2,
  output logic                          ren_ext_2,
  input  logic [63:0]                   rdata_ext_2,
  output logic                          dump_valid,
  input  logic                          dump_ready,
  output logic [63:0]                   dump_data,
  output logic [$clog2(DMEM_DEPTH)-1:0] dump_idx,
  output logic                          busy,
  output logic                          done
);

  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_WAIT,
    S_DUMP_OUT,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [IW-1:0]    widx_reg, widx_next;
  logic [DW-1:0]    didx_reg, didx_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [CNT_W-1:0] rc_reg, rc_next;

  logic             ld_ready_reg, ld_ready_next;
  logic             enable_reg, enable_next;
  logic [63:0]      addr_ext_reg, addr_ext_next;
  logic             wen_ext_reg, wen_ext_next;
  logic [31:0]      wdata_ext_reg, wdata_ext_next;
  logic [63:0]      addr_ext_2_reg, addr_ext_2_next;
  logic             ren_ext_2_reg, ren_ext_2_next;
  logic             dump_valid_reg, dump_valid_next;
  logic [63:0]      dump_data_reg, dump_data_next;
  logic [DW-1:0]    dump_idx_reg, dump_idx_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic start_ok;
  logic ld_hs;
  logic ld_end;
  logic run_end;
  logic dump_hs;

  assign start_ok = start && !abort && (state_reg == S_IDLE || state_reg == S_DONE);
  assign ld_hs    = (state_reg == S_LOAD) && ld_valid && ld_ready_reg;
  assign ld_end   = ld_hs && (ld_last || widx_reg == IW'(IMEM_DEPTH - 1));
  assign dump_hs  = (state_reg == S_DUMP_OUT) && dump_valid_reg && dump_ready;

  // Counter holds the number of RUN cycles already completed, so the current
  // cycle is the last one when the incremented value reaches the target.
  assign cnt_inc = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;
  assign run_end = (cnt_inc == rc_reg);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      unique case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) state_next = S_LOAD;
        end
        S_LOAD: begin
          if (ld_end) state_next = (rc_reg == '0) ? S_DUMP_RD : S_RUN;
        end
        S_RUN: begin
          if (run_end) state_next = S_DUMP_RD;
        end
        S_DUMP_RD:   state_next = S_DUMP_WAIT;
        S_DUMP_WAIT: state_next = S_DUMP_OUT;
        S_DUMP_OUT: begin
          if (dump_hs) state_next = (didx_reg == DW'(DMEM_DEPTH - 1)) ? S_DONE : S_DUMP_RD;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    widx_next = widx_reg;
    didx_next = didx_reg;
    cnt_next  = cnt_reg;
    rc_next   = rc_reg;
    if (start_ok) begin
      widx_next = '0;
      didx_next = '0;
      cnt_next  = '0;
      rc_next   = run_cycles;
    end else begin
      if (ld_hs) widx_next = widx_reg + 1'b1;
      if (state_reg == S_RUN) cnt_next = cnt_inc;
      if (dump_hs) didx_next = didx_reg + 1'b1;
    end
  end

  // Outputs are derived from the upcoming state so every port is a flop.
  always_comb begin
    enable_next     = (state_next == S_RUN);
    ld_ready_next   = (state_next == S_LOAD) && !ld_hs;
    wen_ext_next    = ld_hs && !abort;
    addr_ext_next   = addr_ext_reg;
    wdata_ext_next  = wdata_ext_reg;
    if (ld_hs) begin
      addr_ext_next  = 64'(widx_reg) << 2;
      wdata_ext_next = ld_data;
    end
    ren_ext_2_next  = (state_next == S_DUMP_RD);
    addr_ext_2_next = addr_ext_2_reg;
    if (state_next == S_DUMP_RD) addr_ext_2_next = 64'(didx_next) << 3;
    dump_valid_next = (state_next == S_DUMP_OUT);
    dump_data_next  = dump_data_reg;
    dump_idx_next   = dump_idx_reg;
    if (state_reg == S_DUMP_WAIT) begin
      dump_data_next = rdata_ext_2;
      dump_idx_next  = didx_reg;
    end
    busy_next = !(state_next inside {S_IDLE, S_DONE});
    done_next = (state_next == S_DONE);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      widx_reg       <= '0;
      didx_reg       <= '0;
      cnt_reg        <= '0;
      rc_reg         <= '0;
      ld_ready_reg   <= 1'b0;
      enable_reg     <= 1'b0;
      addr_ext_reg   <= '0;
      wen_ext_reg    <= 1'b0;
      wdata_ext_reg  <= '0;
      addr_ext_2_reg <= '0;
      ren_ext_2_reg  <= 1'b0;
      dump_valid_reg <= 1'b0;
      dump_data_reg  <= '0;
      dump_idx_reg   <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      widx_reg       <= widx_next;
      didx_reg       <= didx_next;
      cnt_reg        <= cnt_next;
      rc_reg         <= rc_next;
      ld_ready_reg   <= ld_ready_next;
      enable_reg     <= enable_next;
      addr_ext_reg   <= addr_ext_next;
      wen_ext_reg    <= wen_ext_next;
      wdata_ext_reg  <= wdata_ext_next;
      addr_ext_2_reg <= addr_ext_2_next;
      ren_ext_2_reg  <= ren_ext_2_next;
      dump_valid_reg <= dump_valid_next;
      dump_data_reg  <= dump_data_next;
      dump_idx_reg   <= dump_idx_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
    end
  end

  assign ld_ready   = ld_ready_reg;
  assign enable     = enable_reg;
  assign addr_ext   = addr_ext_reg;
  assign wen_ext    = wen_ext_reg;
  assign ren_ext    = 1'b0;
  assign wdata_ext  = wdata_ext_reg;
  assign addr_ext_2 = addr_ext_2_reg;
  assign wen_ext_2  = 1'b0;
  assign ren_ext_2  = ren_ext_2_reg;
  assign dump_valid = dump_valid_reg;
  assign dump_data  = dump_data_reg;
  assign dump_idx   = dump_idx_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized bench for cpu_run_ctrl: records every write, enable cycle, read
// and dump handshake, then checks them against the timing rules of a run.
module tb_cpu_run_ctrl;

  localparam int IMEM_DEPTH = 128;
  localparam int DMEM_DEPTH = 128;
  localparam int CNT_W      = 32;
  localparam int DI_W       = $clog2(DMEM_DEPTH);

  logic              clk = 1'b0;
  logic              arst_n;
  logic              start, abort;
  logic [CNT_W-1:0]  run_cycles;
  logic              ld_valid, ld_ready, ld_last;
  logic [31:0]       ld_data;
  logic              enable, wen_ext, ren_ext;
  logic [63:0]       addr_ext;
  logic [31:0]       wdata_ext;
  logic [63:0]       addr_ext_2, rdata_ext_2, dump_data;
  logic              wen_ext_2, ren_ext_2;
  logic              dump_valid, dump_ready, busy, done;
  logic [DI_W-1:0]   dump_idx;

  cpu_run_ctrl #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .abort(abort), .run_cycles(run_cycles),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .enable(enable), .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2),
    .ren_ext_2(ren_ext_2), .rdata_ext_2(rdata_ext_2), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_data(dump_data), .dump_idx(dump_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Data memory model: read data valid exactly one cycle after the read strobe.
  logic [63:0] dmem [DMEM_DEPTH];
  always @(posedge clk) begin
    if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[DI_W+2:3]];
    else           rdata_ext_2 <= {$urandom, $urandom};
  end

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          c;
    logic [63:0] a;
    logic [63:0] d;
  } ev_t;

  ev_t hs_q[$], wr_q[$], ren_q[$], dv_q[$], dh_q[$];
  int  cyc_n = 0;
  int  en_cnt, en_first, en_last, done_rise;
  int  v_rdy, v_stall, v_busy, v_const;
  int  exp_writes;
  bit  load_open, track_busy;
  int  run_no = 0;

  function automatic logic any_out();
    return |{ld_ready, enable, addr_ext, wen_ext, ren_ext, wdata_ext, addr_ext_2,
             wen_ext_2, ren_ext_2, dump_valid, dump_data, dump_idx, busy, done};
  endfunction

  task automatic clear_rec();
    hs_q.delete(); wr_q.delete(); ren_q.delete(); dv_q.delete(); dh_q.delete();
    en_cnt = 0; en_first = -1; en_last = -1; done_rise = -1;
    v_rdy = 0; v_stall = 0; v_busy = 0; v_const = 0;
  endtask

  // Advance one clock and log what the DUT did, sampling 1 time unit after the edge.
  task automatic cyc();
    logic            p_ld_hs, p_dv, p_dr, p_done;
    logic [63:0]     p_dd;
    logic [DI_W-1:0] p_di;
    logic            exp_rdy;
    p_ld_hs = ld_valid && ld_ready;
    p_dv    = dump_valid;
    p_dr    = dump_ready;
    p_dd    = dump_data;
    p_di    = dump_idx;
    p_done  = done;
    @(posedge clk);
    #1;
    cyc_n++;
    if (p_ld_hs) hs_q.push_back('{c: cyc_n - 1, a: 64'd0, d: 64'd0});
    if (wen_ext) wr_q.push_back('{c: cyc_n, a: addr_ext, d: {32'd0, wdata_ext}});
    exp_rdy = load_open && !wen_ext;
    if (ld_ready !== exp_rdy) v_rdy++;
    if (load_open && wr_q.size() >= exp_writes) load_open = 1'b0;
    if (enable) begin
      if (en_cnt == 0) en_first = cyc_n;
      en_last = cyc_n;
      en_cnt++;
    end
    if (ren_ext_2) ren_q.push_back('{c: cyc_n, a: addr_ext_2, d: 64'd0});
    if (dump_valid && !p_dv) dv_q.push_back('{c: cyc_n, a: 64'(dump_idx), d: dump_data});
    if (p_dv && p_dr) dh_q.push_back('{c: cyc_n - 1, a: 64'(p_di), d: p_dd});
    if (p_dv && !p_dr && (!dump_valid || dump_data !== p_dd || dump_idx !== p_di)) v_stall++;
    if (ren_ext_2 && dump_valid) v_stall++;
    if (done && !p_done) done_rise = cyc_n;
    if (ren_ext !== 1'b0 || wen_ext_2 !== 1'b0) v_const++;
    if (track_busy && !done && busy !== 1'b1) v_busy++;
    if (done && busy) v_busy++;
  endtask

  task automatic run_prog(input int nwords, input bit use_last, input int unsigned rc,
                          input int vpct, input int rpct, input int stall_idx);
    int          exp_wr, noffer, wi, stall_left, last_hs;
    logic        hs;
    logic [31:0] words [IMEM_DEPTH + 8];
    for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] = {$urandom, $urandom};
    for (int i = 0; i < IMEM_DEPTH + 8; i++) words[i] = $urandom;
    exp_wr = use_last ? nwords : IMEM_DEPTH;
    noffer = use_last ? nwords : IMEM_DEPTH + 8;
    clear_rec();
    exp_writes = exp_wr;
    load_open  = 1'b1;
    track_busy = 1'b1;
    start = 1'b1; run_cycles = rc;
    cyc();
    start = 1'b0; run_cycles = $urandom;
    check_val("ld_ready_after_start", ld_ready, 1);
    wi = 0;
    stall_left = 5;
    for (int n = 0; n < 4000 && !done; n++) begin
      if (wi < noffer) begin
        ld_valid = ($urandom_range(99) < vpct);
        ld_data  = words[wi];
        ld_last  = use_last && (wi == nwords - 1);
      end else begin
        ld_valid = $urandom_range(1);
        ld_data  = $urandom;
        ld_last  = $urandom_range(1);
      end
      if (stall_idx >= 0 && dump_valid && int'(dump_idx) == stall_idx && stall_left > 0) begin
        dump_ready = 1'b0;
        stall_left--;
      end else begin
        dump_ready = ($urandom_range(99) < rpct);
      end
      start = ($urandom_range(49) == 0);
      hs = ld_valid && ld_ready;
      cyc();
      if (hs && wi < noffer) wi++;
    end
    start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; dump_ready = 1'b0;
    check_val("done_reached", done, 1);
    repeat (3) cyc();
    check_val("done_hold", done, 1);
    check_val("done_busy", busy, 0);

    check_val("hs_count", hs_q.size(), exp_wr);
    check_val("wr_count", wr_q.size(), exp_wr);
    last_hs = (hs_q.size() >= exp_wr) ? hs_q[exp_wr - 1].c : -100;
    for (int i = 0; i < wr_q.size() && i < exp_wr; i++) begin
      check_val("wr_addr", wr_q[i].a, 64'(4 * i));
      check_val("wr_data", wr_q[i].d, 64'(words[i]));
      if (i < hs_q.size()) check_val("wr_latency", wr_q[i].c, hs_q[i].c + 1);
    end
    check_val("en_count", en_cnt, rc);
    if (rc > 0) begin
      check_val("en_first", en_first, last_hs + 1);
      check_val("en_contig", en_last - en_first + 1, rc);
    end
    check_val("ren_count", ren_q.size(), DMEM_DEPTH);
    if (ren_q.size() > 0) check_val("ren_first", ren_q[0].c, last_hs + int'(rc) + 1);
    for (int j = 0; j < ren_q.size() && j < DMEM_DEPTH; j++) begin
      check_val("ren_addr", ren_q[j].a, 64'(8 * j));
      if (j > 0 && j - 1 < dh_q.size()) check_val("ren_after_hs", ren_q[j].c, dh_q[j - 1].c + 1);
      if (j < dv_q.size()) check_val("dv_latency", dv_q[j].c, ren_q[j].c + 2);
    end
    check_val("dh_count", dh_q.size(), DMEM_DEPTH);
    for (int j = 0; j < dh_q.size() && j < DMEM_DEPTH; j++) begin
      check_val("dump_idx", dh_q[j].a, 64'(j));
      check_val("dump_data", dh_q[j].d, dmem[j]);
    end
    if (dh_q.size() > 0) check_val("done_rise", done_rise, dh_q[dh_q.size() - 1].c + 1);
    if (stall_idx >= 0 && rpct == 100 && dh_q.size() > stall_idx && dv_q.size() > stall_idx)
      check_val("stall_len", dh_q[stall_idx].c - dv_q[stall_idx].c, 5);
    check_val("ld_ready_rule", v_rdy, 0);
    check_val("dump_stall_rule", v_stall, 0);
    check_val("busy_rule", v_busy, 0);
    check_val("const_outputs", v_const, 0);
    run_no++;
    $display("run %0d: words=%0d last=%0d rc=%0d writes=%0d enable=%0d dumps=%0d",
             run_no, exp_wr, use_last, rc, wr_q.size(), en_cnt, dh_q.size());
  endtask

  task automatic abort_test();
    int   wi, n_en;
    logic hs;
    clear_rec();
    exp_writes = 4; load_open = 1'b1; track_busy = 1'b0;
    start = 1'b1; run_cycles = 10;
    cyc();
    start = 1'b0;
    wi = 0; n_en = 0;
    for (int n = 0; n < 200 && n_en < 4; n++) begin
      ld_valid = (wi < 4);
      ld_data  = $urandom;
      ld_last  = (wi == 3);
      hs = ld_valid && ld_ready;
      cyc();
      if (hs) wi++;
      if (enable) n_en++;
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check_val("abort_run_cycles_seen", n_en, 4);
    abort = 1'b1; load_open = 1'b0;
    cyc();
    abort = 1'b0;
    check_val("abort_enable", enable, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_done", done, 0);
    cyc();
    check_val("abort_idle_hold", busy | enable | ren_ext_2, 0);
    $display("abort after %0d enable cycles", n_en);
  endtask

  task automatic start_abort_test();
    check_val("sa_pre_done", done, 1);
    track_busy = 1'b0; load_open = 1'b0;
    start = 1'b1; abort = 1'b1; run_cycles = 5;
    cyc();
    start = 1'b0; abort = 1'b0;
    check_val("sa_busy", busy, 0);
    check_val("sa_done", done, 0);
    check_val("sa_ld_ready", ld_ready, 0);
    cyc();
    check_val("sa_idle_hold", busy, 0);
    $display("start with abort from DONE");
  endtask

  task automatic reset_test();
    logic hs;
    clear_rec();
    exp_writes = 1; load_open = 1'b1; track_busy = 1'b0;
    start = 1'b1; run_cycles = 0;
    cyc();
    start = 1'b0;
    ld_valid = 1'b1; ld_data = $urandom; ld_last = 1'b1; dump_ready = 1'b0;
    for (int n = 0; n < 50 && !dump_valid; n++) begin
      hs = ld_valid && ld_ready;
      cyc();
      if (hs) ld_valid = 1'b0;
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check_val("rst_pre_dump_valid", dump_valid, 1);
    #2 arst_n = 1'b0;
    #1;
    check_val("rst_async_outs", any_out(), 0);
    @(negedge clk);
    arst_n = 1'b1;
    load_open = 1'b0;
    cyc();
    check_val("rst_release_busy", busy, 0);
    check_val("rst_release_ld_ready", ld_ready, 0);
    check_val("rst_release_dump_valid", dump_valid, 0);
    $display("reset during dump output");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    arst_n = 1'b0; start = 1'b0; abort = 1'b0; run_cycles = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; dump_ready = 1'b0;
    load_open = 1'b0; track_busy = 1'b0; exp_writes = 0;
    clear_rec();
    #12;
    check_val("reset_outs", any_out(), 0);
    @(negedge clk);
    arst_n = 1'b1;
    cyc(); cyc();
    check_val("idle_busy", busy, 0);
    check_val("idle_ld_ready", ld_ready, 0);

    run_prog(4, 1'b1, 10, 100, 100, -1);
    run_prog(0, 1'b0, 5, 100, 100, -1);
    run_prog(6, 1'b1, 0, 70, 100, -1);
    run_prog(5, 1'b1, 3, 100, 100, 3);
    abort_test();
    run_prog(4, 1'b1, 10, 100, 100, -1);
    start_abort_test();
    reset_test();
    run_prog(3, 1'b1, 2, 80, 60, -1);
    for (int r = 0; r < 4; r++) begin
      run_prog($urandom_range(IMEM_DEPTH, 1), $urandom_range(3) != 0, $urandom_range(20),
               $urandom_range(100, 30), $urandom_range(100, 30),
               ($urandom_range(1) == 1) ? int'($urandom_range(DMEM_DEPTH - 1)) : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
